c7bbiu_ird: RTL and testbench
=============================

C7BBIU_IRD -- requirements
Module: c7bbiu_ird

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: icu_biu_req  in  1  fetch request, held until ack; icu_biu_addr  in  29 [31:3]  fetch address; icu_biu_single  in  1  single-beat request.
REQ-004 SHALL have ports: biu_icu_ack  out  1  request accepted, one-cycle pulse; biu_icu_data_valid  out  1  beat valid; biu_icu_data_last  out  1  final beat; biu_icu_data  out  64  beat data; biu_icu_fault  out  1  transfer error.
REQ-005 SHALL have ports: biu_arvalid  out  1; biu_arready  in  1; biu_araddr  out  32; biu_arlen  out  8; biu_arsize  out  3; biu_arburst  out  2.
REQ-006 SHALL have ports: biu_rvalid  in  1; biu_rready  out  1; biu_rdata  in  64; biu_rresp  in  2; biu_rlast  in  1.

Function
REQ-007 SHALL implement FSM states IDLE, ACK, AR, R.
REQ-008 IDLE: icu_biu_req=1 -> latch icu_biu_addr and icu_biu_single, go to ACK; icu_biu_req=0 -> stay in IDLE.
REQ-009 ACK: biu_icu_ack=1 for exactly this cycle; icu_biu_req is ignored; go to AR.
REQ-010 AR: biu_arvalid=1, with address and control held stable until biu_arready=1; then go to R. arready already high on the first AR cycle -> one AR cycle.
REQ-011 Line fill (single=0): araddr={addr[31:5],5'b0}, arlen=3, arsize=3'b011, arburst=INCR. Beats return in ascending line order.
REQ-012 Single (single=1): araddr={addr[31:3],3'b0}, arlen=0, arsize=3'b011, arburst=INCR.
REQ-013 R: biu_rready=1 in every R cycle (no backpressure); biu_rready=0 in all other states.
REQ-014 Each R-state beat with rvalid=1 SHALL produce exactly one biu_icu_data_valid pulse carrying biu_rdata.
REQ-015 A 2-bit beat counter SHALL clear on entry to AR and increment per accepted beat. Expected last beat: count 3 for a fill, count 0 for a single.
REQ-016 biu_icu_data_last SHALL assert with the expected last beat only, regardless of biu_rlast. After that beat, return to IDLE.
REQ-017 Fault: rresp[1]=1 on any beat, or biu_rlast disagreeing with the expected-last position, sets a sticky flag. biu_icu_fault=1 with the last beat if the flag or the current beat is faulty; the flag clears in IDLE. All beats are still delivered.
REQ-018 rvalid outside the R state SHALL be ignored.
REQ-019 Earliest new request acceptance: the cycle after last is issued. Back-to-back transfers SHALL carry no stale fault or count.
REQ-020 biu_icu_data SHALL be 0 when biu_icu_data_valid=0.

Reset
REQ-021 resetn=0 SHALL asynchronously force IDLE and drive every output to 0: ack, data_valid, data_last, data, fault, arvalid, araddr, arlen, arsize, arburst, rready.
REQ-022 Reset during ACK, AR or R SHALL abandon the transfer; no further ack, data or last is produced. The external bus is reset by the same resetn.

Configuration
REQ-023 Macro C7BBIU_RSP_REG_EN defined: data_valid, data_last, data and fault are registered, giving first beat at the icache one cycle after the R handshake.
REQ-024 Macro C7BBIU_RSP_REG_EN undefined: those outputs are combinational from the R channel, giving zero-cycle latency. Valid, last, data and fault stay mutually aligned in both builds.

Verification
REQ-025 Fill: req with addr=0x0000_1048>>3, arready immediate, 4 beats 0xA0..0xA3 with rlast on beat 3 -> ack pulse 1 cycle after req; araddr=0x0000_1040, arlen=3; 4 valid beats in order, last with 0xA3, fault=0.
REQ-026 Single: req with single=1, addr=0x2008>>3 -> araddr=0x2008, arlen=0; one beat with valid and last together.
REQ-027 Error: fill with rresp=2'b10 on beat 1 -> all 4 beats delivered; fault=1 only on the last beat; the next fill with OKAY responses gives fault=0.
REQ-028 Stall: arready low 5 cycles and rvalid gaps of 2 cycles -> arvalid and araddr stable throughout; exactly 4 valid pulses; rlast early on beat 2 -> fault=1 at beat 3.
REQ-029 Reset mid-R after 2 beats -> all outputs 0 immediately; no further beats; a fresh request after reset completes normally.
REQ-030 Run REQ-025 in both macro builds -> beat timing differs by exactly 1 cycle; data identical.

Source files
------------

// File: rtl/c7bbiu_ird_if.sv
// Icache fetch request/response and AXI read-channel bundle for c7bbiu_ird.
// The slave modport is the bridge's view; master is the icache/bus side.
interface c7bbiu_ird_if;
  localparam int unsigned ADDR_W = 29;
  localparam int unsigned DATA_W = 64;

  logic              icu_biu_req;
  logic [ADDR_W-1:0] icu_biu_addr;
  logic              icu_biu_single;
  logic              biu_icu_ack;
  logic              biu_icu_data_valid;
  logic              biu_icu_data_last;
  logic [DATA_W-1:0] biu_icu_data;
  logic              biu_icu_fault;

  logic              biu_arvalid;
  logic              biu_arready;
  logic [31:0]       biu_araddr;
  logic [7:0]        biu_arlen;
  logic [2:0]        biu_arsize;
  logic [1:0]        biu_arburst;
  logic              biu_rvalid;
  logic              biu_rready;
  logic [DATA_W-1:0] biu_rdata;
  logic [1:0]        biu_rresp;
  logic              biu_rlast;

  modport slave (
    input  icu_biu_req, icu_biu_addr, icu_biu_single,
           biu_arready, biu_rvalid, biu_rdata, biu_rresp, biu_rlast,
    output biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_data, biu_icu_fault,
           biu_arvalid, biu_araddr, biu_arlen, biu_arsize, biu_arburst, biu_rready
  );

  modport master (
    output icu_biu_req, icu_biu_addr, icu_biu_single,
           biu_arready, biu_rvalid, biu_rdata, biu_rresp, biu_rlast,
    input  biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_data, biu_icu_fault,
           biu_arvalid, biu_araddr, biu_arlen, biu_arsize, biu_arburst, biu_rready
  );
endinterface

// File: rtl/c7bbiu_ird.sv
// Icache read bridge: turns a fetch request into one AXI read (4-beat line fill or single beat).
// C7BBIU_RSP_REG_EN: register the icache response outputs (adds one cycle of latency).
module c7bbiu_ird (
  input  logic        clk,
  input  logic        resetn,
  c7bbiu_ird_if.slave bus
);
  localparam int unsigned ADDR_W = 29;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {IDLE, ACK, AR, R} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                single_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic                flt_q;
  logic                ack_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [31:0]         araddr_q;
  logic [7:0]          arlen_q;
  logic [2:0]          arsize_q;
  logic [1:0]          arburst_q;

  logic beat_c, last_c, beat_flt_c, fault_c;
  logic unused_rresp0;

  // A beat is any rvalid while in R; rready is unconditionally high there.
  assign beat_c        = (state == R) & bus.biu_rvalid;
  assign last_c        = beat_c & (beat_cnt == (single_q ? CNT_W'(0) : CNT_W'(3)));
  assign beat_flt_c    = bus.biu_rresp[1] | (bus.biu_rlast != last_c);
  assign fault_c       = last_c & (flt_q | beat_flt_c);
  assign unused_rresp0 = bus.biu_rresp[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      single_q  <= 1'b0;
      beat_cnt  <= '0;
      flt_q     <= 1'b0;
      ack_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          flt_q <= 1'b0;
          if (bus.icu_biu_req) begin
            addr_q   <= bus.icu_biu_addr;
            single_q <= bus.icu_biu_single;
            ack_q    <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          arvalid_q <= 1'b1;
          araddr_q  <= single_q ? {addr_q, 3'b000} : {addr_q[ADDR_W-1:2], 5'b00000};
          arlen_q   <= single_q ? 8'd0 : 8'd3;
          arsize_q  <= 3'b011;
          arburst_q <= 2'b01;
          beat_cnt  <= '0;
          state     <= AR;
        end
        AR: begin
          if (bus.biu_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (beat_c) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_flt_c) flt_q <= 1'b1;
            if (last_c) begin
              rready_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.biu_icu_ack = ack_q;
  assign bus.biu_arvalid = arvalid_q;
  assign bus.biu_araddr  = araddr_q;
  assign bus.biu_arlen   = arlen_q;
  assign bus.biu_arsize  = arsize_q;
  assign bus.biu_arburst = arburst_q;
  assign bus.biu_rready  = rready_q;

`ifdef C7BBIU_RSP_REG_EN
  logic              valid_q, last_q, fault_q;
  logic [DATA_W-1:0] data_q;

  // Response stage: all four fields move together so they stay aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= beat_c;
      last_q  <= last_c;
      fault_q <= fault_c;
      data_q  <= beat_c ? bus.biu_rdata : '0;
    end
  end

  assign bus.biu_icu_data_valid = valid_q;
  assign bus.biu_icu_data_last  = last_q;
  assign bus.biu_icu_fault      = fault_q;
  assign bus.biu_icu_data       = data_q;
`else
  assign bus.biu_icu_data_valid = beat_c;
  assign bus.biu_icu_data_last  = last_c;
  assign bus.biu_icu_fault      = fault_c;
  assign bus.biu_icu_data       = beat_c ? bus.biu_rdata : '0;
`endif
endmodule

// File: tb/tb_c7bbiu_ird.sv
// Randomised bench for c7bbiu_ird against a transaction-level model of the fetch/AXI read protocol.
module tb_c7bbiu_ird;
`ifdef C7BBIU_RSP_REG_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model output from the previous cycle, used when the response path is registered.
  logic        hv = 1'b0, hl = 1'b0, hf = 1'b0;
  logic [63:0] hd = '0;

  c7bbiu_ird_if bus ();

  c7bbiu_ird dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: inputs already driven at the negedge; sample just after, then advance.
  task automatic tick(input logic e_ack, input logic e_arv, input logic e_rrdy,
                      input logic v, input logic [63:0] d, input logic l, input logic f,
                      input logic [31:0] e_addr, input logic [7:0] e_len);
    logic ev, el, ef;
    logic [63:0] ed;
    #1;
    if (LAT == 0) begin
      ev = v;  ed = d;  el = l;  ef = f;
    end else begin
      ev = hv; ed = hd; el = hl; ef = hf;
    end
    check("ack", 64'(bus.biu_icu_ack), 64'(e_ack));
    check("arvalid", 64'(bus.biu_arvalid), 64'(e_arv));
    check("rready", 64'(bus.biu_rready), 64'(e_rrdy));
    check("data_valid", 64'(bus.biu_icu_data_valid), 64'(ev));
    check("data", bus.biu_icu_data, ed);
    check("data_last", 64'(bus.biu_icu_data_last), 64'(el));
    check("fault", 64'(bus.biu_icu_fault), 64'(ef));
    if (e_arv) begin
      check("araddr", 64'(bus.biu_araddr), 64'(e_addr));
      check("arlen", 64'(bus.biu_arlen), 64'(e_len));
      check("arsize", 64'(bus.biu_arsize), 64'd3);
      check("arburst", 64'(bus.biu_arburst), 64'd1);
    end
    hv = v; hd = d; hl = l; hf = f;
    @(negedge clk);
  endtask

  task automatic idle_tick();
    bus.biu_rvalid = 1'($urandom_range(0, 1));
    bus.biu_rdata  = {$urandom, $urandom};
    tick(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 8'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(bus.biu_icu_ack), 64'd0);
    check({tag, "_valid"}, 64'(bus.biu_icu_data_valid), 64'd0);
    check({tag, "_last"}, 64'(bus.biu_icu_data_last), 64'd0);
    check({tag, "_data"}, bus.biu_icu_data, 64'd0);
    check({tag, "_fault"}, 64'(bus.biu_icu_fault), 64'd0);
    check({tag, "_arvalid"}, 64'(bus.biu_arvalid), 64'd0);
    check({tag, "_araddr"}, 64'(bus.biu_araddr), 64'd0);
    check({tag, "_arlen"}, 64'(bus.biu_arlen), 64'd0);
    check({tag, "_arsize"}, 64'(bus.biu_arsize), 64'd0);
    check({tag, "_arburst"}, 64'(bus.biu_arburst), 64'd0);
    check({tag, "_rready"}, 64'(bus.biu_rready), 64'd0);
  endtask

  // One fetch transaction. err_beat/early_beat < 0 disable that error; rst_after > 0 resets after that many beats.
  task automatic txn(input logic [28:0] a, input logic single, input int ar_wait, input int gap,
                     input int err_beat, input int early_beat, input int rst_after,
                     input logic rand_data, input logic [63:0] base);
    int          n;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic        any_err, is_last, bad;
    logic [63:0] d;
    n       = single ? 1 : 4;
    e_addr  = single ? {a, 3'b000} : {a[28:2], 5'b00000};
    e_len   = single ? 8'd0 : 8'd3;
    any_err = 1'b0;

    bus.icu_biu_req    = 1'b1;
    bus.icu_biu_addr   = a;
    bus.icu_biu_single = single;
    bus.biu_arready    = 1'b0;
    bus.biu_rvalid     = 1'($urandom_range(0, 1));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 8'd0);

    // Acknowledge cycle: request inputs and stray rvalid must not matter.
    bus.icu_biu_addr   = 29'($urandom);
    bus.icu_biu_single = 1'($urandom_range(0, 1));
    bus.biu_rvalid     = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 8'd0);
    bus.icu_biu_req = 1'b0;

    for (int c = 0; c <= ar_wait; c++) begin
      bus.biu_arready = (c == ar_wait);
      bus.biu_rvalid  = 1'($urandom_range(0, 1));
      bus.biu_rdata   = {$urandom, $urandom};
      tick(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, e_addr, e_len);
    end
    bus.biu_arready = 1'b0;

    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) begin
        bus.biu_rvalid = 1'b0;
        bus.biu_rdata  = {$urandom, $urandom};
        bus.biu_rlast  = 1'($urandom_range(0, 1));
        bus.biu_rresp  = 2'($urandom_range(0, 3));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 8'd0);
      end
      d = rand_data ? {$urandom, $urandom} : base + 64'(b);
      is_last = (b == n - 1);
      bus.biu_rvalid = 1'b1;
      bus.biu_rdata  = d;
      bus.biu_rresp  = (b == err_beat) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      bus.biu_rlast  = (early_beat >= 0) ? (b == early_beat) : is_last;
      bad     = bus.biu_rresp[1] | (bus.biu_rlast != is_last);
      any_err = any_err | bad;
      tick(1'b0, 1'b0, 1'b1, 1'b1, d, is_last, is_last & any_err, 32'd0, 8'd0);

      if (b + 1 == rst_after) begin
        bus.biu_rvalid = 1'b1;
        bus.biu_rdata  = {$urandom, $urandom};
        resetn = 1'b0;
        #1;
        check_all_zero("rst");
        hv = 1'b0; hd = '0; hl = 1'b0; hf = 1'b0;
        @(negedge clk);
        check_all_zero("rst_hold");
        resetn = 1'b1;
        idle_tick();
        idle_tick();
        bus.biu_rvalid = 1'b0;
        return;
      end
    end
    bus.biu_rvalid = 1'b0;
    idle_tick();
    bus.biu_rvalid = 1'b0;
  endtask

  initial begin
    bus.icu_biu_req    = 1'b0;
    bus.icu_biu_addr   = '0;
    bus.icu_biu_single = 1'b0;
    bus.biu_arready    = 1'b0;
    bus.biu_rvalid     = 1'b0;
    bus.biu_rdata      = '0;
    bus.biu_rresp      = '0;
    bus.biu_rlast      = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle_tick();

    // Directed: fill, single, error + clean follow-up, stalls with early rlast, reset mid-R + recovery.
    txn(29'h209, 1'b0, 0, 0, -1, -1, 0, 1'b0, 64'hA0);
    txn(29'h401, 1'b1, 0, 0, -1, -1, 0, 1'b0, 64'h55);
    txn(29'h1234, 1'b0, 0, 0, 1, -1, 0, 1'b1, 64'd0);
    txn(29'h1238, 1'b0, 0, 0, -1, -1, 0, 1'b1, 64'd0);
    txn(29'h0ABC, 1'b0, 5, 2, -1, 2, 0, 1'b1, 64'd0);
    txn(29'h0777, 1'b0, 1, 0, -1, -1, 2, 1'b1, 64'd0);
    txn(29'h209, 1'b0, 0, 0, -1, -1, 0, 1'b0, 64'hA0);

    for (int i = 0; i < 40; i++) begin
      txn(29'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
          0, 1'b1, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
